rr_req_arbiter: RTL

//   Round-robin arbiter sharing one resource between N requesters. Issues a one-hot

---
 rtl/rr_req_arbiter_if.sv | 40 ++++
 rtl/rr_req_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter_if.sv
// rr_req_arbiter_if: request/grant bundle between N requesters and the arbiter.
//   req      requester -> arbiter, level request per requester
//   gnt      arbiter -> requesters, one-hot registered grant
//   gnt_vld  arbiter -> requesters, registered, 1 when gnt != 0
//   gnt_id   arbiter -> requesters, registered owner index (0 when idle)
//   any_req  arbiter -> upstream, combinational OR of req
//   tmo      arbiter -> requesters, 1-cycle pulse when owner hit the hold limit
// The N parameter must match the N of the arbiter it is connected to.
interface rr_req_arbiter_if #(
    parameter int unsigned N = 4
) ();
    localparam int unsigned ID_W = $clog2(N);

    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic            gnt_vld;
    logic [ID_W-1:0] gnt_id;
    logic            any_req;
    logic            tmo;

    // Requester side
    modport master (
        output req,
        input  gnt,
        input  gnt_vld,
        input  gnt_id,
        input  any_req,
        input  tmo
    );

    // Arbiter side
    modport slave (
        input  req,
        output gnt,
        output gnt_vld,
        output gnt_id,
        output any_req,
        output tmo
    );
endinterface

// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: round-robin arbiter sharing one resource between N requesters.
// The owner keeps a one-hot registered grant while its request stays up, for at
// most HOLD_MAX cycles (0 = unlimited). One idle cycle separates two owners.
// Ports:
//   ck    clock, rising edge
//   nrst  asynchronous active-low reset
//   bus   rr_req_arbiter_if.slave (req in; gnt, gnt_vld, gnt_id, tmo registered
//         outs; any_req combinational out)
module rr_req_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic             ck,
    input  logic             nrst,
    rr_req_arbiter_if.slave  bus
);
    localparam int unsigned ID_W  = $clog2(N);
    localparam int unsigned CNT_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic            gnt_vld_q, gnt_vld_d;
    logic            tmo_q, tmo_d;

    logic            found;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] ptr_after_owner;

    // Rotating priority scan starting at ptr
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            logic [31:0] idx;
            idx = (32'(ptr_q) + i) % N;
            if (!found && bus.req[ID_W'(idx)]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    // Owner N-1 wraps the pointer back to 0
    assign ptr_after_owner = (gnt_id_q == ID_W'(N - 1)) ? '0 : gnt_id_q + ID_W'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        tmo_d     = 1'b0;

        unique case (state_q)
            // GAP arbitrates on its exit edge so exactly one idle cycle is seen
            IDLE, GAP: begin
                if (found) begin
                    gnt_d     = N'(1) << pick;
                    gnt_id_d  = pick;
                    gnt_vld_d = 1'b1;
                    cnt_d     = CNT_W'(1);
                    state_d   = BUSY;
                end else begin
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    gnt_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            BUSY: begin
                if (!bus.req[gnt_id_q] ||
                    ((HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX)))) begin
                    // Release or preemption: owner becomes lowest priority
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    gnt_vld_d = 1'b0;
                    ptr_d     = ptr_after_owner;
                    tmo_d     = bus.req[gnt_id_q];
                    state_d   = GAP;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.tmo     = tmo_q;
    assign bus.any_req = |bus.req;

endmodule
